// File: rtl/psum_wb_pkg.sv
// psum_writeback shared types: FSM state codes, default widths and
// the pass base-address product used by the address generator.
package psum_wb_pkg;

  localparam int PSUM_BW = 16;
  localparam int COL     = 8;
  localparam int PMEM_AW = 9;
  localparam int NIJ_W   = 7;
  localparam int KIJ_W   = 4;
  localparam int PROD_W  = KIJ_W + NIJ_W;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_DRAIN = 2'd1;
  localparam state_t S_FLUSH = 2'd2;
  localparam state_t S_DONE  = 2'd3;

  // Full-width product so the overflow check never sees a wrapped base.
  function automatic logic [PROD_W-1:0] calc_base(
    input logic [KIJ_W-1:0] k,
    input logic [NIJ_W-1:0] n
  );
    return PROD_W'(k) * PROD_W'(n);
  endfunction

endpackage

// File: rtl/psum_wb_addr_gen.sv
// PMEM address generator: latches base=kij*len_nij on start, counts rows.
// Ports: start/inc in, kij/len_nij in; addr, last, ovf (range check) out.
module psum_wb_addr_gen
  import psum_wb_pkg::*;
#(
  parameter int addr_w = PMEM_AW,
  parameter int nij_w  = NIJ_W,
  parameter int kij_w  = KIJ_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              inc,
  input  logic [kij_w-1:0]  kij,
  input  logic [nij_w-1:0]  len_nij,
  output logic [addr_w-1:0] addr,
  output logic              last,
  output logic              ovf
);

  localparam int PW = kij_w + nij_w;
  localparam int SW = PW + 1;
  localparam logic [SW-1:0] LIMIT = SW'(1) << addr_w;

  logic [PW-1:0]     prod;
  logic [SW-1:0]     end_x;
  logic [addr_w-1:0] base_q;
  logic [nij_w-1:0]  len_q;
  logic [nij_w-1:0]  cnt_q;

  assign prod = calc_base(kij, len_nij);

  // base+len > 2^addr_w  <=>  last row address past the top of PMEM.
  assign end_x = {1'b0, prod} + SW'(len_nij);
  assign ovf   = (len_nij == '0) | (end_x > LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_q <= '0;
      len_q  <= '0;
      cnt_q  <= '0;
    end else if (start) begin
      base_q <= prod[addr_w-1:0];
      len_q  <= len_nij;
      cnt_q  <= '0;
    end else if (inc) begin
      cnt_q  <= cnt_q + nij_w'(1);
    end
  end

  assign addr = base_q + addr_w'(cnt_q);
  assign last = (cnt_q == len_q - nij_w'(1));

endmodule

// File: rtl/psum_writeback.sv
// OFIFO -> PMEM psum row writer; ports: start/kij/len_nij/pause, OFIFO
// pop side, registered PMEM pins, busy/done/ovf (+cksum if PSUM_WB_CKSUM_EN).
module psum_writeback
  import psum_wb_pkg::*;
#(
  parameter int col     = COL,
  parameter int psum_bw = PSUM_BW,
  parameter int addr_w  = PMEM_AW,
  parameter int nij_w   = NIJ_W,
  parameter int kij_w   = KIJ_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [kij_w-1:0]       kij,
  input  logic [nij_w-1:0]       len_nij,
  input  logic                   pause,
  input  logic                   ofifo_valid,
  input  logic [col*psum_bw-1:0] ofifo_data,
  output logic                   ofifo_rd,
  output logic                   CEN_pmem,
  output logic                   WEN_pmem,
  output logic [addr_w-1:0]      A_pmem,
  output logic [col*psum_bw-1:0] D_pmem,
  output logic                   busy,
  output logic                   done,
  output logic                   ovf
`ifdef PSUM_WB_CKSUM_EN
  ,
  output logic [psum_bw-1:0]     cksum
`endif
);

  state_t            state_q;
  logic              pop;
  logic              go;
  logic              bad;
  logic              last;
  logic [addr_w-1:0] addr;

  assign pop      = (state_q == S_DRAIN) & ofifo_valid & ~pause;
  assign go       = (state_q == S_IDLE) & start;
  assign ofifo_rd = pop;
  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_DONE);

  psum_wb_addr_gen #(
    .addr_w (addr_w),
    .nij_w  (nij_w),
    .kij_w  (kij_w)
  ) u_addr (
    .clk     (clk),
    .reset   (reset),
    .start   (go),
    .inc     (pop),
    .kij     (kij),
    .len_nij (len_nij),
    .addr    (addr),
    .last    (last),
    .ovf     (bad)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      CEN_pmem <= 1'b1;
      WEN_pmem <= 1'b1;
      A_pmem   <= '0;
      D_pmem   <= '0;
      ovf      <= 1'b0;
    end else begin
      CEN_pmem <= ~pop;
      WEN_pmem <= ~pop;
      if (pop) begin
        A_pmem <= addr;
        D_pmem <= ofifo_data;
      end
      if (go && bad)
        ovf <= 1'b1;
      unique case (1'b1)
        (state_q == S_IDLE):
          if (start)
            state_q <= bad ? S_DONE : S_DRAIN;
        (state_q == S_DRAIN):
          if (pop && last)
            state_q <= S_FLUSH;
        (state_q == S_FLUSH):
          state_q <= S_DONE;
        (state_q == S_DONE):
          state_q <= S_IDLE;
        default:
          state_q <= S_IDLE;
      endcase
    end
  end

`ifdef PSUM_WB_CKSUM_EN
  logic [psum_bw-1:0] fold;

  always_comb begin
    fold = '0;
    for (int i = 0; i < col; i++)
      fold = fold ^ ofifo_data[i*psum_bw +: psum_bw];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cksum <= '0;
    else if (go)
      cksum <= '0;
    else if (pop)
      cksum <= cksum ^ fold;
  end
`endif

endmodule

// File: tb/tb_psum_writeback.sv
// Directed bench for psum_writeback: FIFO model, PMEM write log,
// one task per scenario with inline expected-value checks.
module tb_psum_writeback;
  import psum_wb_pkg::*;

  localparam int W = COL * PSUM_BW;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [3:0]   kij;
  logic [6:0]   len_nij;
  logic         pause;
  logic         ofifo_valid;
  logic [W-1:0] ofifo_data;
  logic         ofifo_rd;
  logic         CEN_pmem;
  logic         WEN_pmem;
  logic [8:0]   A_pmem;
  logic [W-1:0] D_pmem;
  logic         busy;
  logic         done;
  logic         ovf;
`ifdef PSUM_WB_CKSUM_EN
  logic [15:0]  cksum;
`endif

  int vec = 0;
  int err = 0;

  always #5 clk = ~clk;

  psum_writeback dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .kij         (kij),
    .len_nij     (len_nij),
    .pause       (pause),
    .ofifo_valid (ofifo_valid),
    .ofifo_data  (ofifo_data),
    .ofifo_rd    (ofifo_rd),
    .CEN_pmem    (CEN_pmem),
    .WEN_pmem    (WEN_pmem),
    .A_pmem      (A_pmem),
    .D_pmem      (D_pmem),
    .busy        (busy),
    .done        (done),
    .ovf         (ovf)
`ifdef PSUM_WB_CKSUM_EN
    ,
    .cksum       (cksum)
`endif
  );

  // FWFT FIFO model; pops use the strobe seen at the preceding negedge.
  logic [W-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  bit fifo_clr = 1'b0;
  bit rd_s = 1'b0;

  assign ofifo_valid = (rd_ptr < wr_ptr);
  assign ofifo_data  = mem[rd_ptr[9:0]];

  always @(posedge clk)
    if (fifo_clr)  rd_ptr <= wr_ptr;
    else if (rd_s) rd_ptr <= rd_ptr + 1;

  // Negedge monitor: logs writes, pops, done and pause-window address.
  int cyc = 0;
  int wr_n = 0, pop_n = 0, done_n = 0, cen_bad = 0;
  int pa_n = 0, pause_rd = 0, done_cyc = 0, pop_cyc = 0;
  bit rd_prev = 1'b0;
  logic [8:0]   wr_a [0:1023];
  logic [W-1:0] wr_d [0:1023];
  logic [8:0]   pa   [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    rd_s <= ofifo_rd;
    if (!reset) begin
      rd_prev <= 1'b0;
    end else begin
      rd_prev <= ofifo_rd;
      if (ofifo_rd) begin
        pop_n   <= pop_n + 1;
        pop_cyc <= cyc;
      end
      // a write strobe must appear exactly in the cycle after a pop
      if (CEN_pmem !== ~rd_prev || WEN_pmem !== ~rd_prev)
        cen_bad <= cen_bad + 1;
      if (!CEN_pmem && !WEN_pmem) begin
        wr_a[wr_n[9:0]] <= A_pmem;
        wr_d[wr_n[9:0]] <= D_pmem;
        wr_n <= wr_n + 1;
      end
      if (done) begin
        done_n   <= done_n + 1;
        done_cyc <= cyc;
      end
      if (pause) begin
        pa[pa_n[5:0]] <= A_pmem;
        pa_n <= pa_n + 1;
        if (ofifo_rd) pause_rd <= pause_rd + 1;
      end
    end
  end

  function automatic logic [W-1:0] row_of(input int k);
    logic [W-1:0] r;
    for (int j = 0; j < COL; j++)
      r[j*16 +: 16] = 16'(k * 16 + j + 'h1000);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] r);
    mem[wr_ptr[9:0]] = r;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic flush_fifo();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
  endtask

  task automatic go(input int kk, input int ll);
    kij     = 4'(kk);
    len_nij = 7'(ll);
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Stimulus driver: paced arrivals, one pause window, optional abort.
  task automatic run(input int n_rows, input int pace,
                     input int pause_at, input int pause_len,
                     input int abort_at, input int budget,
                     output bit ok);
    int pushed = 0;
    int pctr = 0;
    bit paused = 1'b0;
    int d0 = done_n;
    int p0 = pop_n;
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (pace > 0 && pushed < n_rows && c % pace == 0) begin
        push(row_of(wr_ptr));
        pushed++;
      end
      if (pctr > 0) begin
        pctr--;
        if (pctr == 0) pause = 1'b0;
      end else if (pause_at > 0 && !paused &&
                   pop_n - p0 == pause_at) begin
        pause  = 1'b1;
        pctr   = pause_len;
        paused = 1'b1;
      end
      if (abort_at > 0 && pop_n - p0 == abort_at) begin
        reset = 1'b0;
        ok = 1'b1;
        break;
      end
      tick();
      if (done_n != d0) begin
        ok = 1'b1;
        break;
      end
    end
    pause = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({CEN_pmem, WEN_pmem, busy, done, ovf, ofifo_rd} !== 6'b110000) begin
      err++;
      $display("FAIL reset_ctl got %b%b%b%b%b%b exp 110000",
               CEN_pmem, WEN_pmem, busy, done, ovf, ofifo_rd);
    end
    vec++;
    if (A_pmem !== 9'd0 || D_pmem !== '0) begin
      err++;
      $display("FAIL reset_ad got A=%0d D=%h exp 0", A_pmem, D_pmem);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_burst();
    int w0, f0, p0;
    bit ok;
    flush_fifo();
    w0 = wr_n; p0 = pop_n; f0 = wr_ptr;
    for (int i = 0; i < 64; i++) push(row_of(wr_ptr));
    go(0, 64);
    run(64, 0, 0, 0, 0, 300, ok);
    vec++;
    if (!ok) begin err++; $display("FAIL burst_timeout got none exp done"); end
    vec++;
    if (wr_n - w0 != 64 || pop_n - p0 != 64) begin
      err++;
      $display("FAIL burst_cnt got wr=%0d pop=%0d exp 64", wr_n - w0, pop_n - p0);
    end
    for (int i = 0; i < 64; i++) begin
      vec++;
      if (wr_a[w0+i] !== 9'(i) || wr_d[w0+i] !== mem[f0+i]) begin
        err++;
        $display("FAIL burst_wr%0d got A=%0d exp A=%0d", i, wr_a[w0+i], i);
      end
    end
    vec++;
    if (done_cyc - pop_cyc != 2) begin
      err++;
      $display("FAIL burst_lat got %0d exp 2", done_cyc - pop_cyc);
    end
    @(negedge clk);
    vec++;
    if (busy !== 1'b0 || ovf !== 1'b0) begin
      err++;
      $display("FAIL burst_idle got busy=%b ovf=%b exp 0 0", busy, ovf);
    end
    tick();
  endtask

  task automatic test_paced();
    int w0, f0, c0;
    bit ok;
    flush_fifo();
    w0 = wr_n; f0 = wr_ptr; c0 = cen_bad;
    go(3, 64);
    run(64, 3, 0, 0, 0, 400, ok);
    vec++;
    if (!ok) begin err++; $display("FAIL paced_timeout got none exp done"); end
    vec++;
    if (wr_n - w0 != 64) begin
      err++;
      $display("FAIL paced_cnt got %0d exp 64", wr_n - w0);
    end
    for (int i = 0; i < 64; i++) begin
      vec++;
      if (wr_a[w0+i] !== 9'(192 + i) || wr_d[w0+i] !== mem[f0+i]) begin
        err++;
        $display("FAIL paced_wr%0d got A=%0d exp A=%0d", i, wr_a[w0+i], 192 + i);
      end
    end
    vec++;
    if (cen_bad != c0) begin
      err++;
      $display("FAIL paced_gap got %0d bad strobes exp 0", cen_bad - c0);
    end
    tick();
  endtask

  task automatic test_pause();
    int w0, f0, a0, r0;
    bit ok;
    flush_fifo();
    w0 = wr_n; f0 = wr_ptr; a0 = pa_n; r0 = pause_rd;
    for (int i = 0; i < 16; i++) push(row_of(wr_ptr));
    go(0, 16);
    run(16, 0, 4, 5, 0, 200, ok);
    vec++;
    if (!ok) begin err++; $display("FAIL pause_timeout got none exp done"); end
    vec++;
    if (pa_n - a0 != 5 || pause_rd != r0) begin
      err++;
      $display("FAIL pause_win got cyc=%0d rd=%0d exp 5 0", pa_n - a0, pause_rd - r0);
    end
    for (int i = 0; i < 5; i++) begin
      vec++;
      if (pa[6'(a0 + i)] !== 9'd3) begin
        err++;
        $display("FAIL pause_hold%0d got A=%0d exp 3", i, pa[6'(a0 + i)]);
      end
    end
    vec++;
    if (wr_n - w0 != 16) begin
      err++;
      $display("FAIL pause_cnt got %0d exp 16", wr_n - w0);
    end
    for (int i = 0; i < 16; i++) begin
      vec++;
      if (wr_a[w0+i] !== 9'(i) || wr_d[w0+i] !== mem[f0+i]) begin
        err++;
        $display("FAIL pause_wr%0d got A=%0d exp A=%0d", i, wr_a[w0+i], i);
      end
    end
    tick();
  endtask

  task automatic test_len_zero();
    int w0, p0;
    bit ok;
    flush_fifo();
    w0 = wr_n; p0 = pop_n;
    push(row_of(wr_ptr));
    push(row_of(wr_ptr));
    go(0, 0);
    run(0, 0, 0, 0, 0, 20, ok);
    vec++;
    if (!ok) begin err++; $display("FAIL len0_timeout got none exp done"); end
    vec++;
    if (wr_n != w0 || pop_n != p0 || ovf !== 1'b1) begin
      err++;
      $display("FAIL len0 got wr=%0d pop=%0d ovf=%b exp 0 0 1",
               wr_n - w0, pop_n - p0, ovf);
    end
    tick();
  endtask

  task automatic test_ovf();
    int w0, f0, p0;
    bit ok;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    vec++;
    if (ovf !== 1'b0) begin err++; $display("FAIL ovf_clr got %b exp 0", ovf); end
    flush_fifo();
    w0 = wr_n; p0 = pop_n;
    for (int i = 0; i < 4; i++) push(row_of(wr_ptr));
    go(8, 64);
    run(0, 0, 0, 0, 0, 20, ok);
    vec++;
    if (!ok) begin err++; $display("FAIL ovf_timeout got none exp done"); end
    vec++;
    if (wr_n != w0 || pop_n != p0 || ovf !== 1'b1) begin
      err++;
      $display("FAIL ovf_set got wr=%0d pop=%0d ovf=%b exp 0 0 1",
               wr_n - w0, pop_n - p0, ovf);
    end
    tick();
    flush_fifo();
    w0 = wr_n; f0 = wr_ptr;
    for (int i = 0; i < 64; i++) push(row_of(wr_ptr));
    go(1, 64);
    run(64, 0, 0, 0, 0, 300, ok);
    vec++;
    if (!ok || wr_n - w0 != 64 || ovf !== 1'b1) begin
      err++;
      $display("FAIL ovf_next got done=%b wr=%0d ovf=%b exp 1 64 1",
               ok, wr_n - w0, ovf);
    end
    for (int i = 0; i < 64; i++) begin
      vec++;
      if (wr_a[w0+i] !== 9'(64 + i) || wr_d[w0+i] !== mem[f0+i]) begin
        err++;
        $display("FAIL ovf_wr%0d got A=%0d exp A=%0d", i, wr_a[w0+i], 64 + i);
      end
    end
    tick();
  endtask

  task automatic test_abort();
    int w0, f0, p0;
    bit ok;
    flush_fifo();
    w0 = wr_n; p0 = pop_n;
    for (int i = 0; i < 64; i++) push(row_of(wr_ptr));
    go(0, 64);
    run(64, 0, 0, 0, 10, 200, ok);
    #1;
    vec++;
    if (!ok) begin err++; $display("FAIL abort_timeout got none exp 10 pops"); end
    vec++;
    if ({CEN_pmem, WEN_pmem, busy, done, ovf} !== 5'b11000 ||
        A_pmem !== 9'd0 || D_pmem !== '0) begin
      err++;
      $display("FAIL abort_out got %b%b%b%b%b A=%0d exp 11000 A=0",
               CEN_pmem, WEN_pmem, busy, done, ovf, A_pmem);
    end
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    // the 10th write held the pins for only 1ns before reset hit
    vec++;
    if (wr_n - w0 != 9 || pop_n - p0 != 10) begin
      err++;
      $display("FAIL abort_cnt got wr=%0d pop=%0d exp 9 10", wr_n - w0, pop_n - p0);
    end
    flush_fifo();
    w0 = wr_n; f0 = wr_ptr;
    for (int i = 0; i < 4; i++) push(row_of(wr_ptr));
    go(2, 4);
    run(4, 0, 0, 0, 0, 50, ok);
    vec++;
    if (!ok || wr_n - w0 != 4) begin
      err++;
      $display("FAIL abort_re got done=%b wr=%0d exp 1 4", ok, wr_n - w0);
    end
    for (int i = 0; i < 4; i++) begin
      vec++;
      if (wr_a[w0+i] !== 9'(8 + i) || wr_d[w0+i] !== mem[f0+i]) begin
        err++;
        $display("FAIL abort_wr%0d got A=%0d exp A=%0d", i, wr_a[w0+i], 8 + i);
      end
    end
    tick();
  endtask

`ifdef PSUM_WB_CKSUM_EN
  task automatic test_cksum();
    logic [W-1:0] r;
    bit ok;
    flush_fifo();
    r = '0;
    r[15:0] = 16'h0001;
    push(r);
    r[15:0] = 16'h0003;
    push(r);
    go(0, 2);
    run(2, 0, 0, 0, 0, 30, ok);
    vec++;
    if (!ok || cksum !== 16'h0002) begin
      err++;
      $display("FAIL cksum got done=%b ck=%h exp 1 0002", ok, cksum);
    end
    tick();
  endtask
`endif

  initial begin
    reset   = 1'b0;
    start   = 1'b0;
    pause   = 1'b0;
    kij     = '0;
    len_nij = '0;
    test_reset();
    test_burst();
    test_paced();
    test_pause();
    test_len_zero();
    test_ovf();
    test_abort();
`ifdef PSUM_WB_CKSUM_EN
    test_cksum();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
